// File: rtl/legv8_isa_pkg.sv
// rtl/legv8_isa_pkg.sv - LEGv8 op classes, opcode constants, loader states and error codes
package legv8_isa_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MOVZ = 4'd6,
        OP_B    = 4'd7,
        OP_CBZ  = 4'd8,
        OP_LDUR = 4'd9,
        OP_STUR = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } load_state_e;

    // R-type and D-type carry an 11-bit opcode, I-type 10, IW 9, CB 8, B 6.
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    localparam int IMM_I_W  = 12;
    localparam int IMM_IW_W = 16;
    localparam int IMM_CB_W = 19;
    localparam int IMM_D_W  = 9;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    function automatic logic fits_unsigned(input logic [25:0] imm, input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++)
            if (i >= bits && imm[i]) ok = 1'b0;
        return ok;
    endfunction

    // Signed fit: every bit above the field's sign bit must copy it.
    function automatic logic fits_signed(input logic [25:0] imm, input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++)
            if (i >= bits && imm[i] != imm[bits-1]) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/instr_word_encode.sv
// rtl/instr_word_encode.sv - combinational op class plus fields to 32-bit LEGv8 machine word
module instr_word_encode
    import legv8_isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_err
);

    op_e op_class;
    assign op_class = op_e'(op);

    always_comb begin
        word      = '0;
        illegal   = 1'b0;
        range_err = 1'b0;
        case (op_class)
            OP_AND:  word = {OPC_AND, rm, 6'b000000, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, 6'b000000, rn, rd};
            OP_ADD:  word = {OPC_ADD, rm, 6'b000000, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, 6'b000000, rn, rd};
            OP_ADDI: begin
                word      = {OPC_ADDI, imm[11:0], rn, rd};
                range_err = !fits_unsigned(imm, IMM_I_W);
            end
            OP_SUBI: begin
                word      = {OPC_SUBI, imm[11:0], rn, rd};
                range_err = !fits_unsigned(imm, IMM_I_W);
            end
            OP_MOVZ: begin
                word      = {OPC_MOVZ, hw, imm[15:0], rd};
                range_err = !fits_unsigned(imm, IMM_IW_W);
            end
            OP_B:    word = {OPC_B, imm};
            OP_CBZ: begin
                word      = {OPC_CBZ, imm[18:0], rd};
                range_err = !fits_signed(imm, IMM_CB_W);
            end
            OP_LDUR: begin
                word      = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                range_err = !fits_signed(imm, IMM_D_W);
            end
            OP_STUR: begin
                word      = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                range_err = !fits_signed(imm, IMM_D_W);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - streams symbolic instructions, encodes them and writes them to instruction memory
module instr_encoder_loader
    import legv8_isa_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MAX_WORDS = 1024
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rn,
    input  logic [4:0]                 in_rm,
    input  logic [25:0]                in_imm,
    input  logic [1:0]                 in_hw,
    input  logic                       in_last,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    input  logic                       imem_wready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(MAX_WORDS):0] word_count
);

    localparam int CNT_W = $clog2(MAX_WORDS) + 1;

    load_state_e state, state_next;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        enc_range_err;
    logic        accept;
    logic        wr_done;
    logic        start_ok;
    logic        full;
    logic        load_word;

    instr_word_encode u_enc (
        .op        (in_op),
        .rd        (in_rd),
        .rn        (in_rn),
        .rm        (in_rm),
        .imm       (in_imm),
        .hw        (in_hw),
        .word      (enc_word),
        .illegal   (enc_illegal),
        .range_err (enc_range_err)
    );

    assign accept   = in_valid && in_ready;
    assign wr_done  = imem_we && imem_wready;
    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    // The pending output word counts against the limit, so a full image never overflows.
    assign full      = (word_count + CNT_W'(imem_we)) == CNT_W'(MAX_WORDS);
    assign load_word = accept && !enc_illegal && !enc_range_err && !full;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = !imem_we || imem_wready;
                if (in_valid && in_ready && in_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!imem_we) state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // imem_addr doubles as the address counter: it advances on each completed write.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            if (wr_done) begin
                imem_addr  <= imem_addr + ADDR_W'(4);
                word_count <= word_count + CNT_W'(1);
            end

            if (load_word) begin
                imem_we    <= 1'b1;
                imem_wdata <= enc_word;
            end else if (wr_done) begin
                imem_we <= 1'b0;
            end

            if (accept && !err) begin
                if (enc_illegal) begin
                    err      <= 1'b1;
                    err_code <= ERR_ILLEGAL;
                end else if (enc_range_err) begin
                    err      <= 1'b1;
                    err_code <= ERR_RANGE;
                end else if (full) begin
                    err      <= 1'b1;
                    err_code <= ERR_OVERFLOW;
                end
            end

            if (start_ok) begin
                imem_addr  <= base_addr & ~ADDR_W'(3);
                word_count <= '0;
                err        <= 1'b0;
                err_code   <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int AW     = 64;
    localparam int TB_MAX = 16;
    localparam int CW     = $clog2(TB_MAX) + 1;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rd, in_rn, in_rm;
    logic [25:0]   in_imm;
    logic [1:0]    in_hw;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_wready;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [CW-1:0] word_count;

    instr_encoder_loader #(.ADDR_W(AW), .MAX_WORDS(TB_MAX)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_hw(in_hw), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wready(imem_wready), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int wr_mode = 0;
    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [63:0] m_base;
    int          m_words;
    bit          m_err;
    int          m_code;
    bit          prev_stall = 0;
    logic [63:0] prev_addr;
    logic [31:0] prev_data;
    bit          seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: field values placed by arithmetic weight, ranges checked as integers.
    function automatic void ref_encode(input int op, input logic [4:0] rd, input logic [4:0] rn,
                                       input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
                                       output bit ok, output logic [31:0] w, output int code);
        longint u, s, vd, vn, vm, vh, r;
        u = longint'(imm);
        s = (u >= 2**25) ? u - 2**26 : u;
        vd = longint'(rd); vn = longint'(rn); vm = longint'(rm); vh = longint'(hw);
        ok = 1; code = 0; r = 0;
        case (op)
            0: r = 64'h8A000000 + vm*65536 + vn*32 + vd;
            1: r = 64'hAA000000 + vm*65536 + vn*32 + vd;
            2: r = 64'h8B000000 + vm*65536 + vn*32 + vd;
            3: r = 64'hCB000000 + vm*65536 + vn*32 + vd;
            4: if (u < 4096) r = 64'h91000000 + u*1024 + vn*32 + vd; else code = 2;
            5: if (u < 4096) r = 64'hD1000000 + u*1024 + vn*32 + vd; else code = 2;
            6: if (u < 65536) r = 64'hD2800000 + vh*2097152 + u*32 + vd; else code = 2;
            7: r = 64'h14000000 + u;
            8: if (s >= -262144 && s < 262144) r = 64'hB4000000 + ((s + 524288) % 524288)*32 + vd;
               else code = 2;
            9: if (s >= -256 && s < 256) r = 64'hF8400000 + ((s + 512) % 512)*4096 + vn*32 + vd;
               else code = 2;
            10: if (s >= -256 && s < 256) r = 64'hF8000000 + ((s + 512) % 512)*4096 + vn*32 + vd;
                else code = 2;
            default: code = 1;
        endcase
        if (code != 0) ok = 0;
        w = r[31:0];
    endfunction

    task automatic send_raw(input int op, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                            input logic [25:0] imm, input logic [1:0] hw, input bit last,
                            input bit ok_in, input logic [31:0] w, input int code_in);
        bit ok;
        int code;
        bit acc;
        ok = ok_in; code = code_in; acc = 0;
        if (ok && m_words == TB_MAX) begin
            ok = 0;
            code = 3;
        end
        if (ok) begin
            exp_addr_q.push_back(m_base + 64'(4 * m_words));
            exp_data_q.push_back(w);
            m_words++;
        end
        if (code != 0 && !m_err) begin
            m_err = 1;
            m_code = code;
        end
        @(negedge CLK);
        in_valid = 1; in_op = 4'(op); in_rd = rd; in_rn = rn; in_rm = rm;
        in_imm = imm; in_hw = hw; in_last = last;
        for (int i = 0; i < 200; i++) begin
            #2;
            acc = in_ready;
            @(posedge CLK);
            if (acc) break;
            @(negedge CLK);
        end
        check("accept", 64'(acc), 1);
        #1;
        if (ok) begin
            check("lat_we", imem_we, 1);
            check("lat_data", imem_wdata, w);
        end
        if (last) in_valid = 0;
    endtask

    task automatic send_rand(input int op, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                             input logic [25:0] imm, input logic [1:0] hw, input bit last);
        bit ok;
        logic [31:0] w;
        int code;
        ref_encode(op, rd, rn, rm, imm, hw, ok, w, code);
        send_raw(op, rd, rn, rm, imm, hw, last, ok, w, code);
    endtask

    task automatic rand_beat(input bit last);
        int r;
        int op;
        logic [25:0] imm;
        r = int'($urandom_range(0, 19));
        op = (r < 11) ? r : (r < 13) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
        case ($urandom_range(0, 3))
            0: imm = 26'($urandom);
            1: imm = 26'($urandom_range(0, 4999));
            2: imm = 26'(int'($urandom_range(0, 599)) - 300);
            default: imm = 26'($urandom_range(0, 69999));
        endcase
        send_rand(op, 5'($urandom), 5'($urandom), 5'($urandom), imm, 2'($urandom), last);
    endtask

    task automatic do_start(input logic [63:0] base);
        @(negedge CLK);
        start = 1;
        base_addr = base;
        @(posedge CLK);
        #1;
        start = 0;
        m_base = base & ~64'h3;
        m_words = 0;
        m_err = 0;
        m_code = 0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_err", err, 0);
        check("start_count", word_count, 0);
        check("start_addr", imem_addr, m_base);
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            #2;
            if (done) begin
                got = 1;
                break;
            end
        end
        check("done", 64'(got), 1);
        check("word_count", word_count, 64'(m_words));
        check("err", err, 64'(m_err));
        check("err_code", err_code, 64'(m_code));
        check("idle_busy", busy, 0);
        check("pending_writes", 64'(exp_data_q.size()), 0);
    endtask

    always @(posedge CLK) begin
        #3;
        if (wr_mode == 0)      imem_wready = 1'b1;
        else if (wr_mode == 1) imem_wready = ($urandom_range(0, 2) != 0);
    end

    // Write scoreboard plus hold-while-stalled checks.
    always @(negedge CLK) begin
        #2;
        if (prev_stall) begin
            check("hold_we", imem_we, 1);
            check("hold_addr", imem_addr, prev_addr);
            check("hold_data", imem_wdata, prev_data);
        end
        if (imem_we && !imem_wready) check("stall_in_ready", in_ready, 0);
        if (imem_we && imem_wready) begin
            check("write_expected", 64'(exp_data_q.size() != 0), 1);
            if (exp_data_q.size() != 0) begin
                check("wr_addr", imem_addr, exp_addr_q.pop_front());
                check("wr_data", imem_wdata, exp_data_q.pop_front());
            end
        end
        prev_stall = imem_we && !imem_wready;
        prev_addr  = imem_addr;
        prev_data  = imem_wdata;
    end

    always @(posedge Reset) prev_stall = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1; start = 0; base_addr = '0; in_valid = 0; in_op = '0; in_rd = '0;
        in_rn = '0; in_rm = '0; in_imm = '0; in_hw = '0; in_last = 0; imem_wready = 1;
        m_base = '0; m_words = 0; m_err = 0; m_code = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_count", word_count, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge CLK);
        Reset = 0;

        do_start(64'h100);
        send_raw(2, 1, 2, 3, 26'd0, 2'd0, 0, 1, 32'h8B030041, 0);
        send_raw(4, 4, 4, 0, 26'd5, 2'd0, 1, 1, 32'h91001484, 0);
        wait_done();

        wr_mode = 1;
        do_start(64'h200);
        send_raw(9, 5, 6, 0, 26'h3FFFFF8, 2'd0, 0, 1, 32'hF85F80C5, 0);
        send_raw(10, 5, 6, 0, 26'd256, 2'd0, 0, 0, 32'h0, 2);
        send_raw(7, 0, 0, 0, 26'h3FFFFFF, 2'd0, 0, 1, 32'h17FFFFFF, 0);
        send_raw(8, 9, 0, 0, 26'd3, 2'd0, 0, 1, 32'hB4000069, 0);
        send_raw(6, 0, 0, 0, 26'hABCD, 2'd2, 1, 1, 32'hD2D579A0, 0);
        wait_done();

        do_start(64'h300);
        wr_mode = 2;
        imem_wready = 0;
        fork
            begin
                send_raw(3, 7, 8, 9, 26'd0, 2'd0, 0, 1, 32'hCB090107, 0);
                send_raw(0, 1, 1, 1, 26'd0, 2'd0, 1, 1, 32'h8A010021, 0);
            end
        join_none
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #2;
            if (imem_we) begin
                seen = 1;
                break;
            end
        end
        check("stall_seen", 64'(seen), 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge CLK);
                #2;
            end
            check("stall_we", imem_we, 1);
            check("stall_addr", imem_addr, 64'h300);
            check("stall_data", imem_wdata, 32'hCB090107);
            check("stall_ready", in_ready, 0);
        end
        @(posedge CLK);
        #3;
        imem_wready = 1;
        wait fork;
        wait_done();
        wr_mode = 1;

        do_start(64'h400);
        send_raw(12, 1, 1, 1, 26'd0, 2'd0, 0, 0, 32'h0, 1);
        send_raw(5, 1, 1, 0, 26'd5000, 2'd0, 0, 0, 32'h0, 2);
        send_raw(2, 2, 3, 4, 26'd0, 2'd0, 1, 1, 32'h8B040062, 0);
        wait_done();

        do_start(64'h1000);
        for (int i = 0; i < TB_MAX + 2; i++)
            send_rand(2, 5'($urandom), 5'($urandom), 5'($urandom), 26'd0, 2'd0, i == TB_MAX + 1);
        wait_done();

        for (int l = 0; l < 6; l++) begin
            int n;
            n = int'($urandom_range(1, 12));
            do_start({$urandom, $urandom});
            for (int i = 0; i < n; i++) rand_beat(i == n - 1);
            wait_done();
        end

        do_start(64'h2000);
        wr_mode = 2;
        imem_wready = 0;
        send_rand(2, 5'd3, 5'd4, 5'd5, 26'd0, 2'd0, 0);
        @(negedge CLK);
        #3;
        Reset = 1;
        #1;
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_wdata", imem_wdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_code", err_code, 0);
        check("mid_rst_count", word_count, 0);
        check("mid_rst_in_ready", in_ready, 0);
        in_valid = 0;
        @(negedge CLK);
        Reset = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        wr_mode = 0;
        imem_wready = 1;
        do_start(64'h3002);
        rand_beat(0);
        rand_beat(1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
